// File: rtl/bus_pkg.sv
// Shared bus definitions for the addrData bus arbiter.
//   arb_state_t        : arbiter FSM states
//   BUS_BURST_SINGLE   : single-beat burst code
//   BUS_BE_WORD        : full-word byte enables
//   BUS_NUM_MASTERS    : default requester count
//   BUS_TIMEOUT_CYCLES : default ACTIVE watchdog limit
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic [7:0]  BUS_BURST_SINGLE   = 8'h1;
  localparam logic [3:0]  BUS_BE_WORD        = 4'hF;
  localparam int unsigned BUS_NUM_MASTERS    = 4;
  localparam int unsigned BUS_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin winner selection.
//   req_i    : per-master request vector
//   last_i   : index of the previous owner
//   winner_o : first requester above last_i, wrapping modulo NUM_MASTERS
//   valid_o  : any request present
module rr_picker
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = BUS_NUM_MASTERS,
  parameter int unsigned IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          last_i,
  output logic [IW-1:0]          winner_o,
  output logic                   valid_o
);

  logic [2*NUM_MASTERS-1:0] req2;
  logic [2*NUM_MASTERS-1:0] cand;
  int unsigned              last_u;

  // Requests are doubled so the scan past the top index continues into the
  // upper copy; masking lower-copy bits at or below last_i gives the rotation.
  // The index is folded back with an explicit compare so non-power-of-2
  // master counts wrap correctly.
  always_comb begin
    req2     = {req_i, req_i};
    last_u   = 32'(last_i);
    cand     = '0;
    winner_o = '0;
    for (int unsigned i = 0; i < 2 * NUM_MASTERS; i++) begin
      cand[i] = req2[i] && (i > last_u);
    end
    for (int unsigned i = 2 * NUM_MASTERS; i > 0; i--) begin
      if (cand[i-1]) begin
        winner_o = (i - 1 >= NUM_MASTERS) ? IW'(i - 1 - NUM_MASTERS) : IW'(i - 1);
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared addrData bus. Ownership lasts for one
// begin/end transaction; an idle owner that drops its request loses the
// grant after GRANT_HOLD cycles.
//   clk, rst_n             : clock, synchronous active-low reset
//   arb_request_i          : per-master request levels
//   arb_grant_o            : registered one-hot grant
//   bus_beginTransaction_i : global begin strobe
//   bus_endTransaction_i   : global end strobe
//   bus_busy_i             : global busy, blocks new grants
//   owner_o                : current or last owner index
//   owner_valid_o          : grant held
//   bus_error_o            : one-cycle ACTIVE timeout pulse
// Optional: define BUS_ARB_TIMEOUT_EN to enable the ACTIVE-state watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = BUS_NUM_MASTERS,
  parameter int unsigned GRANT_HOLD     = 4,
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_MASTERS-1:0]         arb_request_i,
  output logic [NUM_MASTERS-1:0]         arb_grant_o,
  input  logic                           bus_beginTransaction_i,
  input  logic                           bus_endTransaction_i,
  input  logic                           bus_busy_i,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_o,
  output logic                           owner_valid_o,
  output logic                           bus_error_o
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);
  localparam int unsigned HW = $clog2(GRANT_HOLD + 1);

  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("bus_arbiter: NUM_MASTERS and TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t       state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic             owner_valid_q, owner_valid_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [IW-1:0]    pick_winner;
  logic             pick_valid;
  logic             go_release;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_picker (
    .req_i    (arb_request_i),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_d        = last_q;
    owner_valid_d = owner_valid_q;
    hold_d        = hold_q;
    go_release    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_d         = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid && !bus_busy_i) begin
          grant_d              = '0;
          grant_d[pick_winner] = 1'b1;
          owner_d              = pick_winner;
          owner_valid_d        = 1'b1;
          hold_d               = '0;
          state_d              = GRANTED;
        end
      end
      GRANTED: begin
        if (bus_beginTransaction_i) begin
          if (bus_endTransaction_i) begin
            go_release = 1'b1;
          end else begin
            state_d = ACTIVE;
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end else if (arb_request_i[owner_q]) begin
          hold_d = '0;
        end else begin
          if (32'(hold_q) < GRANT_HOLD) hold_d = hold_q + 1'b1;
          // Revoke on the idle cycle that brings the count to GRANT_HOLD.
          if (32'(hold_d) >= GRANT_HOLD) go_release = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus_endTransaction_i) begin
          go_release = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        end else if (32'(tmo_q) >= TIMEOUT_CYCLES - 1) begin
          err_d      = 1'b1;
          go_release = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_release) begin
      state_d       = RELEASE;
      grant_d       = '0;
      owner_valid_d = 1'b0;
      last_d        = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_q        <= IW'(NUM_MASTERS - 1);
      owner_valid_q <= 1'b0;
      hold_q        <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      owner_valid_q <= owner_valid_d;
      hold_q        <= hold_d;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_q         <= tmo_d;
      err_q         <= err_d;
`endif
    end
  end

  assign arb_grant_o   = grant_q;
  assign owner_o       = owner_q;
  assign owner_valid_o = owner_valid_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign bus_error_o   = err_q;
`else
  assign bus_error_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter against a transaction-level
// round-robin model. Inputs change and outputs are sampled on the falling
// clock edge.
module tb_bus_arbiter;

  localparam int N   = 4;
  localparam int GH  = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         bgn = 1'b0;
  logic         endt = 1'b0;
  logic         busy = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         owner_valid;
  logic         bus_error;

  int checks = 0;
  int errors = 0;
  int model_last = N - 1;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .GRANT_HOLD     (GH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .arb_request_i          (req),
    .arb_grant_o            (grant),
    .bus_beginTransaction_i (bgn),
    .bus_endTransaction_i   (endt),
    .bus_busy_i             (busy),
    .owner_o                (owner),
    .owner_valid_o          (owner_valid),
    .bus_error_o            (bus_error)
  );

  // Reference: first requester strictly after the previous owner, modulo N.
  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grant(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 20 && !ok) begin
      tick();
      cyc++;
      if (grant != '0) ok = 1'b1;
    end
  endtask

  // Begin and end in the same cycle: the shortest possible transaction.
  task automatic single_word();
    bgn = 1'b1; endt = 1'b1;
    tick();
    bgn = 1'b0; endt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; bgn = 0; endt = 0; busy = 0;
    repeat (3) tick();
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    checks++; if (owner_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", owner_valid); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", bus_error); end
    rst_n = 1'b1;
    model_last = N - 1;
    tick();
  endtask

  task automatic test_single();
    int w;
    req = 4'b0001;
    w = rr_winner(req, model_last);
    tick();
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL single_grant got=%b exp=%b", grant, onehot(w)); end
    checks++; if (owner !== 2'(w)) begin errors++; $display("FAIL single_owner got=%0d exp=%0d", owner, w); end
    checks++; if (owner_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", owner_valid); end
    bgn = 1'b1;
    tick();
    bgn = 1'b0; req = '0;
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL single_active_hold got=%b exp=%b", grant, onehot(w)); end
    tick();
    endt = 1'b1;
    tick();
    endt = 1'b0;
    model_last = w;
    checks++; if (grant !== '0) begin errors++; $display("FAIL single_release got=%b exp=0000", grant); end
    checks++; if (owner_valid !== 1'b0) begin errors++; $display("FAIL single_release_valid got=%b exp=0", owner_valid); end
    checks++; if (owner !== 2'(w)) begin errors++; $display("FAIL single_owner_kept got=%0d exp=%0d", owner, w); end
    tick();
  endtask

  task automatic test_round_robin();
    int cyc, w;
    bit ok;
    rst_n = 1'b0; tick(); rst_n = 1'b1; model_last = N - 1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(cyc, ok);
      if (i > 0) cyc++;
      w = rr_winner(req, model_last);
      checks++; if (!ok) begin errors++; $display("FAIL rr_grant_timeout iter=%0d got=none exp=%0d", i, w); end
      checks++; if (owner !== 2'(w) || grant !== onehot(w)) begin errors++; $display("FAIL rr_order iter=%0d got=%0d/%b exp=%0d", i, owner, grant, w); end
      checks++; if (cyc != (i == 0 ? 1 : 3)) begin errors++; $display("FAIL rr_spacing iter=%0d got=%0d exp=%0d", i, cyc, (i == 0 ? 1 : 3)); end
      model_last = w;
      single_word();
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    int cyc, w;
    bit ok;
    req = 4'b0100;
    wait_grant(cyc, ok);
    w = rr_winner(req, model_last);
    checks++; if (!ok || owner !== 2'(w)) begin errors++; $display("FAIL wrap_first got=%0d exp=%0d", owner, w); end
    model_last = w;
    req = 4'b0101;
    single_word();
    wait_grant(cyc, ok);
    w = rr_winner(req, model_last);
    checks++; if (!ok || owner !== 2'(w) || grant !== onehot(w)) begin errors++; $display("FAIL wrap_past_top got=%0d exp=%0d", owner, w); end
    checks++; if (cyc != 2) begin errors++; $display("FAIL wrap_latency got=%0d exp=2", cyc); end
    model_last = w;
    single_word();
    wait_grant(cyc, ok);
    w = rr_winner(req, model_last);
    checks++; if (!ok || owner !== 2'(w)) begin errors++; $display("FAIL wrap_back got=%0d exp=%0d", owner, w); end
    model_last = w;
    req = '0;
    single_word();
    tick();
  endtask

  task automatic test_hold();
    int cyc, w, n;
    bit ok, dropped;
    req = 4'b0010;
    wait_grant(cyc, ok);
    w = rr_winner(req, model_last);
    checks++; if (!ok || owner !== 2'(w)) begin errors++; $display("FAIL hold_grant got=%0d exp=%0d", owner, w); end
    req = 4'b1000;
    n = 0;
    do begin tick(); n++; end while (grant != '0 && n < 10);
    checks++; if (n != GH) begin errors++; $display("FAIL hold_revoke_cycles got=%0d exp=%0d", n, GH); end
    model_last = w;
    wait_grant(cyc, ok);
    w = rr_winner(req, model_last);
    checks++; if (!ok || owner !== 2'(w)) begin errors++; $display("FAIL hold_next_owner got=%0d exp=%0d", owner, w); end
    checks++; if (cyc != 2) begin errors++; $display("FAIL hold_next_latency got=%0d exp=2", cyc); end
    // Drop 3 cycles, reassert 1, drop 3: never GH consecutive idle cycles.
    dropped = 1'b0;
    for (int k = 0; k < 7; k++) begin
      req = (k == 3) ? 4'b1000 : 4'b0000;
      tick();
      if (grant !== onehot(w)) dropped = 1'b1;
    end
    checks++; if (dropped) begin errors++; $display("FAIL hold_reassert got=revoked exp=held"); end
    model_last = w;
    single_word();
    tick();
  endtask

  task automatic test_busy();
    int cyc, w;
    bit ok, early;
    busy = 1'b1; req = 4'b0001;
    early = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bgn = k[0]; endt = ~k[0];
      tick();
      if (grant != '0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL busy_blocks got=granted exp=none"); end
    bgn = 1'b0; endt = 1'b0; busy = 1'b0;
    tick();
    w = rr_winner(req, model_last);
    checks++; if (grant !== onehot(w) || owner !== 2'(w)) begin errors++; $display("FAIL busy_release_grant got=%b exp=%b", grant, onehot(w)); end
    bgn = 1'b1;
    tick();
    bgn = 1'b0;
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL busy_active got=%b exp=%b", grant, onehot(w)); end
    rst_n = 1'b0; req = 4'b0011;
    tick();
    checks++; if (grant !== '0 || owner_valid !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL reset_in_active got=%b/%b/%0d exp=0000/0/0", grant, owner_valid, owner); end
    rst_n = 1'b1;
    model_last = N - 1;
    wait_grant(cyc, ok);
    w = rr_winner(req, model_last);
    checks++; if (!ok || cyc != 1 || owner !== 2'(w)) begin errors++; $display("FAIL reset_to_idle got=%0d after %0d exp=%0d after 1", owner, cyc, w); end
    model_last = w;
    req = '0;
    single_word();
    tick();
  endtask

  task automatic test_timeout();
    int cyc, w, pulses, at;
    bit ok, held;
    logic [N-1:0] g_at;
    req = 4'b0100;
    wait_grant(cyc, ok);
    w = rr_winner(req, model_last);
    checks++; if (!ok || owner !== 2'(w)) begin errors++; $display("FAIL tmo_grant got=%0d exp=%0d", owner, w); end
    bgn = 1'b1; tick(); bgn = 1'b0; req = '0;
    model_last = w;
`ifdef BUS_ARB_TIMEOUT_EN
    pulses = 0; at = -1; g_at = 'x;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus_error) begin
        pulses++;
        if (at < 0) begin at = n; g_at = grant; end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL tmo_pulse_count got=%0d exp=1", pulses); end
    checks++; if (at != TMO) begin errors++; $display("FAIL tmo_pulse_cycle got=%0d exp=%0d", at, TMO); end
    checks++; if (g_at !== '0) begin errors++; $display("FAIL tmo_grant_released got=%b exp=0000", g_at); end
    req = 4'b0100;
    wait_grant(cyc, ok);
    bgn = 1'b1; tick(); bgn = 1'b0; req = '0;
    pulses = 0;
    for (int n = 1; n < TMO; n++) begin
      tick();
      if (bus_error) pulses++;
    end
    endt = 1'b1; tick(); endt = 1'b0;
    if (bus_error) pulses++;
    checks++; if (grant !== '0) begin errors++; $display("FAIL tmo_end_release got=%b exp=0000", grant); end
    repeat (4) begin tick(); if (bus_error) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL tmo_end_wins got=%0d pulses exp=0", pulses); end
`else
    held = 1'b1; pulses = 0; at = 0; g_at = '0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus_error) pulses++;
      if (grant !== onehot(w)) held = 1'b0;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL tmo_disabled_error got=%0d exp=0", pulses); end
    checks++; if (!held) begin errors++; $display("FAIL tmo_disabled_hold got=dropped exp=held"); end
    endt = 1'b1; tick(); endt = 1'b0;
    checks++; if (grant !== '0) begin errors++; $display("FAIL tmo_disabled_end got=%b exp=0000", grant); end
    tick();
`endif
  endtask

  task automatic test_random();
    int cyc, w, mode, n;
    bit ok, held;
    for (int i = 0; i < 40; i++) begin
      req = 4'($urandom_range(1, 15));
      wait_grant(cyc, ok);
      w = rr_winner(req, model_last);
      checks++; if (!ok || owner !== 2'(w) || grant !== onehot(w)) begin errors++; $display("FAIL rand_winner iter=%0d req=%b got=%0d exp=%0d", i, req, owner, w); end
      checks++; if (cyc != (i == 0 ? 1 : 2)) begin errors++; $display("FAIL rand_latency iter=%0d got=%0d exp=%0d", i, cyc, (i == 0 ? 1 : 2)); end
      model_last = w;
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        single_word();
      end else if (mode == 1) begin
        bgn = 1'b1; tick(); bgn = 1'b0;
        held = 1'b1;
        repeat ($urandom_range(0, 5)) begin
          req = 4'($urandom_range(0, 15));
          tick();
          if (grant !== onehot(w)) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("FAIL rand_active_hold iter=%0d got=dropped exp=held", i); end
        endt = 1'b1; tick(); endt = 1'b0;
      end else begin
        req[w] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (grant != '0 && n < 10);
        checks++; if (n != GH) begin errors++; $display("FAIL rand_abandon iter=%0d got=%0d exp=%0d", i, n, GH); end
      end
      checks++; if (grant !== '0 || owner_valid !== 1'b0) begin errors++; $display("FAIL rand_release iter=%0d got=%b/%b exp=0000/0", i, grant, owner_valid); end
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold();
    test_busy();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
